// File: rtl/vga_frame_scanout.sv
// vga_frame_scanout
//   Consumer end of the PPU-to-VGA pixel path. PPU pixel writes go into a
//   256x240x8 frame buffer. The buffer is scanned out with 640x480 VGA
//   timing, scaled 2x and centred horizontally.
//
//   Optional build macro: VGA_FB_REPEAT_EN. When it is defined, frames that
//   start with no new PPU frame queued still display the buffer. When it is
//   undefined, such frames show BLANK_INDEX over the whole active area.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   vga_row/col/data  PPU pixel write coordinates and palette index
//   vga_write_en      write strobe, one pixel per cycle
//   ppu_vsync         one-cycle pulse: PPU finished a frame
//   vga_done          1 = buffer free for PPU writes, 0 = readout in progress
//   hsync, vsync      active-low syncs
//   de                display enable
//   pixel_index       palette index for the current pixel
//   write_collision   sticky flag: a write arrived while vga_done=0
module vga_frame_scanout #(
    parameter int          PIX_DIV     = 2,
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          H_OFFSET    = 64,
    parameter logic [7:0]  BLANK_INDEX = 8'h0F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] vga_row,
    input  logic [8:0] vga_col,
    input  logic [7:0] vga_data,
    input  logic       vga_write_en,
    input  logic       ppu_vsync,
    output logic       vga_done,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [7:0] pixel_index,
    output logic       write_collision
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW       = 12;
    localparam int DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int FB_DEPTH = 256 * 240;

    localparam logic [CW-1:0] H_MAX = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_S  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_E  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_S  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_E  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] WIN_S = CW'(H_OFFSET);
    localparam logic [CW-1:0] WIN_E = CW'(H_OFFSET + 511);

`ifdef VGA_FB_REPEAT_EN
    localparam logic REPEAT = 1'b1;
`else
    localparam logic REPEAT = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_READOUT} state_t;

    state_t         state;
    logic           pending;
    logic           show_frame;
    logic [DW-1:0]  div;
    logic           pe;
    logic [CW-1:0]  h_cnt, v_cnt, h_nxt, v_nxt;
    logic [CW-1:0]  hd_nxt;
    logic [15:0]    rd_addr, wr_addr;
    logic [7:0]     rd_data;
    logic           wr_ok;
    logic           frame_start, frame_end;
    logic           show_eff, de_c, hs_lo, vs_lo;

    logic [7:0] fb [0:FB_DEPTH-1];

    function automatic logic in_win(input logic [CW-1:0] h, input logic [CW-1:0] v);
        return (h >= WIN_S) && (h <= WIN_E) && (v < V_ACT);
    endfunction

    assign pe = (div == DW'(PIX_DIV - 1));

    always_comb begin
        h_nxt = h_cnt + CW'(1);
        v_nxt = v_cnt;
        if (h_cnt == H_MAX) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_MAX) ? '0 : v_cnt + CW'(1);
        end
    end

    // The buffer is read on pe using the position the counters are about to
    // take. The data is then ready when the output stage registers that same
    // position one pe later. This holds for any PIX_DIV, including 1.
    assign hd_nxt  = h_nxt - WIN_S;
    assign rd_addr = {8'(v_nxt >> 1), 8'(hd_nxt >> 1)};
    assign wr_addr = {vga_row[7:0], vga_col[7:0]};
    assign wr_ok   = vga_write_en && vga_done && (vga_row < 9'd240) && !vga_col[8];

    assign frame_start = pe && (h_cnt == '0) && (v_cnt == '0);
    assign frame_end   = pe && (h_cnt == '0) && (v_cnt == V_ACT);

    // At the first pixel of a frame, the show decision is taken from the
    // state that is just being left. After that, the latched value is used.
    assign show_eff = frame_start ? ((state == ST_PENDING) || REPEAT) : show_frame;
    assign de_c     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_lo    = (h_cnt >= HS_S) && (h_cnt <= HS_E);
    assign vs_lo    = (v_cnt >= VS_S) && (v_cnt <= VS_E);

    always_ff @(posedge clk) begin
        if (wr_ok)
            fb[wr_addr] <= vga_data;
    end

    always_ff @(posedge clk) begin
        if (pe && in_win(h_nxt, v_nxt))
            rd_data <= fb[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div <= pe ? '0 : div + DW'(1);
            if (pe) begin
                h_cnt <= h_nxt;
                v_cnt <= v_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            pixel_index <= BLANK_INDEX;
        end else if (pe) begin
            hsync       <= !hs_lo;
            vsync       <= !vs_lo;
            de          <= de_c;
            pixel_index <= (de_c && in_win(h_cnt, v_cnt) && show_eff) ? rd_data : BLANK_INDEX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            write_collision <= 1'b0;
        else if (vga_write_en && !vga_done)
            write_collision <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            vga_done   <= 1'b1;
            show_frame <= 1'b0;
        end else begin
            if (frame_start)
                show_frame <= show_eff;
            case (state)
                ST_IDLE: begin
                    if (ppu_vsync) begin
                        pending <= 1'b1;
                        state   <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (frame_start) begin
                        // A pulse in this very cycle queues the following frame.
                        pending  <= ppu_vsync;
                        vga_done <= 1'b0;
                        state    <= ST_READOUT;
                    end else if (ppu_vsync) begin
                        pending <= 1'b1;
                    end
                end
                ST_READOUT: begin
                    if (frame_end) begin
                        vga_done <= 1'b1;
                        pending  <= pending || ppu_vsync;
                        state    <= (pending || ppu_vsync) ? ST_PENDING : ST_IDLE;
                    end else if (ppu_vsync) begin
                        pending <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
